// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 word packer
//
// PS2_BREAK / PS2_EXT : scan-code prefix bytes (break, extended)
// ps2_filt_state_e    : break-filter FSM states
// ps2_word_t          : packed word at the default 4-byte width
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic {
        FILT_PASS = 1'b0,
        FILT_SKIP = 1'b1
    } ps2_filt_state_e;

    typedef logic [31:0] ps2_word_t;

endpackage

// File: rtl/ps2_word_fifo.sv
// rtl/ps2_word_fifo.sv - first-word fall-through queue of {addr, data} entries
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, wdata_i   write request and entry
//   pop_i             consume head entry (ignored when empty)
//   push_ok_o         this cycle's push is accepted (room, or a same-cycle pop)
//   rdata_o           head entry, zero while empty
//   valid_o           queue not empty
//   level_o           entries held
module ps2_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic                       push_ok_o,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q, level_d;
    logic             pop_ok;
    logic             full;

    assign full      = (level_q == LW'(DEPTH));
    assign pop_ok    = pop_i && (level_q != '0);
    // When full, the pushed entry lands in the slot being popped this edge.
    assign push_ok_o = push_i && (!full || pop_ok);

    always_comb begin
        level_d = level_q;
        if (push_ok_o && !pop_ok) begin
            level_d = level_q + LW'(1);
        end else if (pop_ok && !push_ok_o) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            level_q <= level_d;
            if (push_ok_o) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_o) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    assign valid_o = (level_q != '0);
    assign rdata_o = valid_o ? mem_q[rd_q] : '0;
    assign level_o = level_q;

endmodule

// File: rtl/ps2_word_packer.sv
// rtl/ps2_word_packer.sv - packs PS/2 receive bytes into addressed words and queues them
//
// Optional feature: define PS2_BREAK_FILTER_EN to drop break codes (F0 and the
// byte following it) before they reach the assembler.
//
// Ports:
//   clk_i, reset_ni                   clock, asynchronous active-low reset
//   byte_valid_i, byte_data_i         one-cycle byte strobe and data
//   flush_i                           push a partial word, zero-padded
//   word_data_o, word_addr_o          head-of-queue word and its store address
//   word_valid_o, word_ready_i        queue handshake
//   fill_count_o                      bytes held in the assembler
//   fifo_level_o                      words queued
//   overflow_o, clr_overflow_i        sticky dropped-word flag and its clear
import ps2_pkg::*;

module ps2_word_packer #(
    parameter int                BYTES_PER_WORD = 4,
    parameter int                FIFO_DEPTH     = 4,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(32'h0000_AAAA),
    parameter int                ADDR_STEP      = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                byte_valid_i,
    input  logic [7:0]                          byte_data_i,
    input  logic                                flush_i,
    output logic [8*BYTES_PER_WORD-1:0]         word_data_o,
    output logic [ADDR_W-1:0]                   word_addr_o,
    output logic                                word_valid_o,
    input  logic                                word_ready_i,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0] fill_count_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level_o,
    output logic                                overflow_o,
    input  logic                                clr_overflow_i
);

    localparam int BPW = BYTES_PER_WORD;
    localparam int DW  = 8 * BPW;
    localparam int FW  = $clog2(BPW + 1);

    logic              byte_take;
    logic [DW-1:0]     asm_q, asm_d, asm_word;
    logic [FW-1:0]     fill_q, fill_d, asm_fill;
    logic              word_push;
    logic              push_ok;
    logic              pop;
    logic [ADDR_W-1:0] addr_q;
    logic              ovf_q;
    logic [ADDR_W+DW-1:0] fifo_rdata;

`ifdef PS2_BREAK_FILTER_EN
    ps2_filt_state_e filt_q, filt_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            filt_q <= FILT_PASS;
        end else begin
            filt_q <= filt_d;
        end
    end

    // Only byte strobes move the filter, so a flush never disturbs SKIP.
    always_comb begin
        filt_d    = filt_q;
        byte_take = byte_valid_i;
        if (byte_valid_i) begin
            case (filt_q)
                FILT_PASS: begin
                    if (byte_data_i == PS2_BREAK) begin
                        byte_take = 1'b0;
                        filt_d    = FILT_SKIP;
                    end
                end
                FILT_SKIP: begin
                    byte_take = 1'b0;
                    filt_d    = FILT_PASS;
                end
            endcase
        end
    end
`else
    assign byte_take = byte_valid_i;
`endif

    // The byte is appended first; completion and flush are judged on the
    // post-append fill so a completing byte plus flush pushes only once.
    always_comb begin
        asm_word = asm_q;
        asm_fill = fill_q;
        if (byte_take) begin
            for (int i = 0; i < BPW; i++) begin
                if (fill_q == FW'(i)) begin
                    asm_word[8*(BPW-1-i) +: 8] = byte_data_i;
                end
            end
            asm_fill = fill_q + FW'(1);
        end
        word_push = (asm_fill == FW'(BPW)) || (flush_i && (asm_fill != '0));
        // Clearing on push keeps unused low lanes zero for the next flush.
        asm_d  = word_push ? '0 : asm_word;
        fill_d = word_push ? '0 : asm_fill;
    end

    assign pop = word_valid_o && word_ready_i;

    ps2_word_fifo #(
        .WIDTH (ADDR_W + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (reset_ni),
        .push_i    (word_push),
        .wdata_i   ({addr_q, asm_word}),
        .pop_i     (pop),
        .push_ok_o (push_ok),
        .rdata_o   (fifo_rdata),
        .valid_o   (word_valid_o),
        .level_o   (fifo_level_o)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            asm_q  <= '0;
            fill_q <= '0;
            addr_q <= BASE_ADDR;
            ovf_q  <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            fill_q <= fill_d;
            // A dropped word does not consume an address.
            if (push_ok) begin
                addr_q <= addr_q + ADDR_W'(ADDR_STEP);
            end
            if (word_push && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (clr_overflow_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign word_addr_o  = fifo_rdata[ADDR_W+DW-1:DW];
    assign word_data_o  = fifo_rdata[DW-1:0];
    assign fill_count_o = fill_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ps2_word_packer.sv
// tb/tb_ps2_word_packer.sv - self-checking bench for ps2_word_packer
module tb_ps2_word_packer;
    import ps2_pkg::*;

    localparam int          BPW   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_AAAA;
    localparam int          STEP  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        flush;
    logic [31:0] word_data;
    logic [31:0] word_addr;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fill_count;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        clr_ovf;

    ps2_word_packer #(
        .BYTES_PER_WORD (BPW),
        .FIFO_DEPTH     (DEPTH),
        .ADDR_W         (32),
        .BASE_ADDR      (BASE),
        .ADDR_STEP      (STEP)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (rst_n),
        .byte_valid_i   (byte_valid),
        .byte_data_i    (byte_data),
        .flush_i        (flush),
        .word_data_o    (word_data),
        .word_addr_o    (word_addr),
        .word_valid_o   (word_valid),
        .word_ready_i   (word_ready),
        .fill_count_o   (fill_count),
        .fifo_level_o   (fifo_level),
        .overflow_o     (overflow),
        .clr_overflow_i (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes of the word being built, queued words, next address.
    logic [7:0]  m_cur[$];
    ps2_word_t   m_data[$];
    logic [31:0] m_addr[$];
    logic [31:0] m_next;
    logic        m_ovf;
    bit          m_skip;
    bit          m_pop, m_push, m_full, m_take, m_drop;
    ps2_word_t   m_w;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_cur.delete();
                m_data.delete();
                m_addr.delete();
                m_next = BASE;
                m_ovf  = 1'b0;
                m_skip = 1'b0;
            end else begin
                m_pop  = (m_data.size() > 0) && word_ready;
                m_take = byte_valid;
`ifdef PS2_BREAK_FILTER_EN
                if (byte_valid) begin
                    if (m_skip) begin
                        m_take = 1'b0;
                        m_skip = 1'b0;
                    end else if (byte_data == PS2_BREAK) begin
                        m_take = 1'b0;
                        m_skip = 1'b1;
                    end
                end
`endif
                if (m_take) m_cur.push_back(byte_data);
                m_push = (m_cur.size() == BPW) || (flush && m_cur.size() > 0);
                m_full = (m_data.size() == DEPTH);
                m_drop = 1'b0;
                if (m_pop) begin
                    void'(m_data.pop_front());
                    void'(m_addr.pop_front());
                end
                if (m_push) begin
                    m_w = '0;
                    for (int i = 0; i < m_cur.size(); i++)
                        m_w = m_w | (ps2_word_t'(m_cur[i]) << (8 * (BPW - 1 - i)));
                    if (!m_full || m_pop) begin
                        m_data.push_back(m_w);
                        m_addr.push_back(m_next);
                        m_next = m_next + STEP;
                    end else begin
                        m_drop = 1'b1;
                    end
                    m_cur.delete();
                end
                if (m_drop) m_ovf = 1'b1;
                else if (clr_ovf) m_ovf = 1'b0;
            end
            #2;
            chk("valid", word_valid, m_data.size() > 0);
            chk("data", word_data, (m_data.size() > 0) ? m_data[0] : 32'h0);
            chk("addr", word_addr, (m_addr.size() > 0) ? m_addr[0] : 32'h0);
            chk("fill", fill_count, m_cur.size());
            chk("level", fifo_level, m_data.size());
            chk("overflow", overflow, m_ovf);
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic f, input logic r);
        @(negedge clk);
        byte_valid = v;
        byte_data  = d;
        flush      = f;
        word_ready = r;
    endtask

    task automatic send4(input logic [31:0] w, input logic r);
        for (int i = 3; i >= 0; i--) drive(1'b1, w[8*i +: 8], 1'b0, r);
    endtask

    initial begin
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; flush = 1'b0;
        word_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", word_valid, 1'b0);
        chk("rst_data", word_data, 32'h0);
        chk("rst_addr", word_addr, 32'h0);
        chk("rst_fill", fill_count, 3'd0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // Word assembly with a ready consumer
        send4(32'h1C322123, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t1_valid", word_valid, 1'b1);
        chk("t1_data", word_data, 32'h1C322123);
        chk("t1_addr", word_addr, 32'h0000AAAA);
        send4(32'h1B242B34, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t1b_data", word_data, 32'h1B242B34);
        chk("t1b_addr", word_addr, 32'h0000AAAE);

        // Flush of a partial word, then flush with nothing held
        drive(1'b1, 8'h1C, 1'b0, 1'b1);
        drive(1'b1, 8'h32, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_data", word_data, 32'h1C320000);
        chk("t2_addr", word_addr, 32'h0000AAB2);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_empty_flush", word_valid, 1'b0);

        // Completing byte together with flush pushes exactly one word
        drive(1'b1, 8'hA1, 1'b0, 1'b1);
        drive(1'b1, 8'hA2, 1'b0, 1'b1);
        drive(1'b1, 8'hA3, 1'b0, 1'b1);
        drive(1'b1, 8'hA4, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2c_data", word_data, 32'hA1A2A3A4);
        chk("t2c_level", fifo_level, 3'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2c_single", word_valid, 1'b0);

        // Backpressure and overflow from a fresh reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 5; k++) send4(32'h01020304 + 32'h10101010 * k, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_level", fifo_level, 3'd4);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_head", word_addr, 32'h0000AAAA);
        clr_ovf = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        clr_ovf = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_clr", overflow, 1'b0);

        // Push into a full FIFO with a simultaneous pop
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        drive(1'b1, 8'h88, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_level", fifo_level, 3'd4);
        chk("t4_ovf", overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_addr", word_addr, BASE + 32'(STEP * (i + 1)));
            word_ready = 1'b1;
            @(negedge clk);
        end
        chk("t4_empty", word_valid, 1'b0);

        // Reset in the middle of a word
        drive(1'b1, 8'h1C, 1'b0, 1'b1);
        drive(1'b1, 8'h32, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_fill2", fill_count, 3'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_fill0", fill_count, 3'd0);
        @(negedge clk); rst_n = 1'b1;
        send4(32'h11223344, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_data", word_data, 32'h11223344);
        chk("t5_addr", word_addr, BASE);

`ifdef PS2_BREAK_FILTER_EN
        // Break code and its follower are dropped; the extended prefix passes
        drive(1'b1, 8'h1C, 1'b0, 1'b1);
        drive(1'b1, PS2_BREAK, 1'b0, 1'b1);
        drive(1'b1, 8'h1C, 1'b0, 1'b1);
        drive(1'b1, 8'h32, 1'b0, 1'b1);
        drive(1'b1, PS2_EXT, 1'b0, 1'b1);
        drive(1'b1, 8'h75, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_data", word_data, 32'h1C32E075);
        chk("t6_addr", word_addr, 32'h0000AAAE);
`endif

        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_word_packer.md
# ps2_word_packer

Parametrised successor to the PS/2 peripheral's 4-byte buffer. Takes the byte stream from the PS/2 keyboard receiver (one-cycle `rx_done_tick`-style strobe plus 8-bit data), packs `BYTES_PER_WORD` bytes into one word, tags each word with an incrementing store address, and queues completed words in a small FIFO. The FIFO is drained by the I/O module over a valid/ready handshake. It replaces the fixed 32-bit, no-backpressure, fixed-address buffer path.

## Interface
- `BYTES_PER_WORD`, 4: bytes per output word; legal range 1..8.
- `FIFO_DEPTH`, 4: words of output queue; power of two, at least 2.
- `ADDR_W`, 32: store-address width.
- `BASE_ADDR`, 32'h0000_AAAA: address of the first word after reset.
- `ADDR_STEP`, 4: address increment per pushed word.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `byte_valid`  in  1  one-cycle strobe: `byte_data` is valid.
- `byte_data`  in  8  received scan-code byte.
- `flush`  in  1  pulse: push the partial word, zero-padded.
- `word_data`  out  8*BYTES_PER_WORD  head-of-FIFO word.
- `word_addr`  out  ADDR_W  store address of the head word.
- `word_valid`  out  1  FIFO not empty.
- `word_ready`  in  1  consumer accepts the head word when high with `word_valid`.
- `fill_count`  out  $clog2(BYTES_PER_WORD+1)  bytes currently held in the assembler.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  words queued.
- `overflow`  out  1  sticky: at least one word has been dropped.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- Assembler: shift register plus `fill_count`. The first received byte lands in the MSB lane `[8*BPW-1 -: 8]`; later bytes fill the lanes below it.
- A word completes when the accepted byte makes `fill_count` reach `BYTES_PER_WORD`. On that same edge:
  - the word is pushed;
  - `fill_count` returns to 0.
- `flush` with `fill_count` > 0 pushes the held bytes left-justified, with the low lanes zero. `flush` with `fill_count` = 0 does nothing.
- `flush` and `byte_valid` in the same cycle: the byte is appended first, then the flush applies.
  - If that byte completes the word, exactly one word is pushed.
  - The flush then finds `fill_count` = 0 and does nothing.
- Address counter: starts at `BASE_ADDR`. Each push stores the current value with the word, then adds `ADDR_STEP`; the sum wraps modulo 2^ADDR_W.
- FIFO: first-word fall-through; `word_data`/`word_addr` are valid whenever `word_valid` is high. A pop happens when `word_valid && word_ready`.
- Full FIFO on a push:
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the word is dropped: `overflow` is set, the address counter does not advance, and the assembler still clears.
- `overflow` setting has priority over `clr_overflow` in the same cycle.
- Reset values: `fill_count` = 0, `fifo_level` = 0, `word_valid` = 0, `overflow` = 0, `word_data` = 0, `word_addr` = 0, address counter = `BASE_ADDR`, filter state PASS.
- Reset asserted mid-word or mid-FIFO discards all held data immediately.

## Timing
- Push to `word_valid`: `word_valid` rises in the cycle after the edge that pushed into an empty FIFO (1-cycle latency from the final `byte_valid`).
- Pop: on the edge where `word_valid && word_ready`, the next entry is presented in the following cycle, or `word_valid` falls if the FIFO empties.
- Back-to-back `byte_valid` every cycle is supported with no loss while the FIFO has space.
- Registered outputs: `fill_count`, `fifo_level` and `overflow` are all registered.
- `word_ready` may be held high permanently; in that case each word is visible for exactly one cycle.

## Configuration
- `PS2_BREAK_FILTER_EN` defined: a filter FSM sits in front of the assembler.
  - States: PASS, SKIP.
  - In PASS, byte 8'hF0 is discarded and the FSM goes to SKIP.
  - In SKIP, the next byte is discarded and the FSM returns to PASS.
  - 8'hE0 and all other bytes pass unchanged.
  - `flush` in SKIP does not change the filter state.
- Macro undefined: all bytes pass; no filter logic is generated.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_BREAK` = 8'hF0;
  - `PS2_EXT` = 8'hE0;
  - the filter state enum;
  - a `ps2_word_t` typedef used at the default 4-byte width.
- Sub-module `ps2_word_fifo` (parametrised depth/width, FWFT, level output). It stores `{addr, data}` per entry.
- The assembler, address counter and filter live in the top module.

## Test plan
- Word assembly: bytes 8'h1C, 8'h32, 8'h21, 8'h23 with `word_ready`=1 -> one cycle later `word_valid`=1, `word_data`=32'h1C322123, `word_addr`=32'h0000AAAA. A second word carries `word_addr` 32'h0000AAAE.
- Flush: bytes 8'h1C, 8'h32 then `flush` -> `word_data`=32'h1C320000. `flush` with `fill_count`=0 -> no word.
- Backpressure/overflow: `word_ready`=0, 5 full words with `FIFO_DEPTH`=4 -> `fifo_level`=4, `overflow`=1, the 5th word is absent, and the next accepted word's address is BASE+16.
- Push into a full FIFO with a simultaneous pop -> `fifo_level` stays 4 and `overflow` stays 0.
- Filter (`PS2_BREAK_FILTER_EN`): bytes 1C F0 1C 32 E0 75 -> packed word 32'h1C32E075.
- Reset mid-word: 2 bytes, assert `reset` -> `fill_count`=0. The next 4 bytes form a clean word at `BASE_ADDR`.
